// File: rtl/grp_mp_pkg.sv
// ---------------------------------------------------------------------------
// grp_mp_pkg
//   Shared definitions for the multi-port general register file (grp_mp).
//   Holds the default widths, the register reset constant, the read-port
//   source select type and the packed-bus slice helper.
//   Optional feature macro used by the importing files: GRP_MP_BYPASS_EN.
// ---------------------------------------------------------------------------
package grp_mp_pkg;

  localparam int DEFAULT_DW = 32;
  localparam int DEFAULT_AW = 5;

  // Value every register takes on reset.
  localparam logic [31:0] INITIAL_VAL_32 = 32'h0000_0000;

  // Where a read port takes its data from.
  typedef enum logic [1:0] {
    SRC_ARRAY = 2'd0,  // pre-edge register contents
    SRC_WB0   = 2'd1,  // same-cycle ALU writeback
    SRC_WB1   = 2'd2   // same-cycle load return
  } rd_src_e;

  // LSB position of lane idx in a packed bus of w-bit lanes.
  function automatic int slice_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/grp_mp_rdport.sv
// ---------------------------------------------------------------------------
// grp_mp_rdport
//   One decode read port of grp_mp: zero-register check, optional
//   writeback bypass, and the pending-load (rbusy) indication.
//   Optional feature macro: GRP_MP_BYPASS_EN (same-cycle write forwarding).
// Ports:
//   rst_i                 synchronous reset; forces rdata/rbusy to 0
//   raddr_i               register address read by this port
//   arr_data_i/arr_busy_i register contents and busy bit at raddr_i
//   wen0_i/waddr0_i/wdata0_i  ALU writeback (bypass source)
//   wen1_i/waddr1_i/wdata1_i  load return (bypass source, wins over port 0)
//   rdata_o/rbusy_o       combinational read data and pending-load flag
// ---------------------------------------------------------------------------
module grp_mp_rdport
  import grp_mp_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) (
  input  logic          rst_i,
  input  logic [AW-1:0] raddr_i,
  input  logic [DW-1:0] arr_data_i,
  input  logic          arr_busy_i,
  input  logic          wen0_i,
  input  logic [AW-1:0] waddr0_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic          wen1_i,
  input  logic [AW-1:0] waddr1_i,
  input  logic [DW-1:0] wdata1_i,
  output logic [DW-1:0] rdata_o,
  output logic          rbusy_o
);

  rd_src_e src;

`ifdef GRP_MP_BYPASS_EN
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    src = SRC_ARRAY;
    if (wen1_i && (waddr1_i == raddr_i))      src = SRC_WB1;
    else if (wen0_i && (waddr0_i == raddr_i)) src = SRC_WB0;
  end
`else
  assign src = SRC_ARRAY;

  // Writeback inputs only feed the bypass; tie them off in this build.
  logic unused_wb;
  assign unused_wb = ^{wen0_i, waddr0_i, wdata0_i, wen1_i, waddr1_i, wdata1_i};
`endif

  always_comb begin
    rdata_o = arr_data_i;
    rbusy_o = arr_busy_i;
    case (src)
      SRC_WB1: begin
        // The load data is being forwarded, so decode need not stall.
        rdata_o = wdata1_i;
        rbusy_o = 1'b0;
      end
      SRC_WB0: rdata_o = wdata0_i;
      default: ;
    endcase
    // Register 0 and reset both read as zero; this also hides any
    // same-cycle write to address 0 from the bypass path.
    if (rst_i || (raddr_i == '0)) begin
      rdata_o = '0;
      rbusy_o = 1'b0;
    end
  end

endmodule

// File: rtl/grp_mp.sv
// ---------------------------------------------------------------------------
// grp_mp
//   Multi-port general register file with two write ports (0: ALU,
//   1: load return, wins on same-address conflict), NUM_RD combinational
//   read ports and a per-register pending-load scoreboard.
//   Optional feature macro: GRP_MP_BYPASS_EN (same-cycle write forwarding
//   to the read ports, handled in grp_mp_rdport).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   raddr/rdata/rbusy     packed read ports, port i at [i*W +: W]
//   wen0/waddr0/wdata0    ALU writeback
//   wen1/waddr1/wdata1    load-return writeback (clears busy)
//   iss_en/iss_addr       load issue (sets busy)
//   busy_vec              raw scoreboard state
// ---------------------------------------------------------------------------
module grp_mp
  import grp_mp_pkg::*;
#(
  parameter int DW     = DEFAULT_DW,
  parameter int AW     = DEFAULT_AW,
  parameter int NUM_RD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_RD*DW-1:0] rdata,
  output logic [NUM_RD-1:0]    rbusy,
  input  logic                 wen0,
  input  logic [AW-1:0]        waddr0,
  input  logic [DW-1:0]        wdata0,
  input  logic                 wen1,
  input  logic [AW-1:0]        waddr1,
  input  logic [DW-1:0]        wdata1,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic [2**AW-1:0]     busy_vec
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;

  // Scoreboard next state: a same-cycle issue overrides the load return so
  // back-to-back loads to one destination keep the register pending.
  always_comb begin
    busy_d = busy_q;
    if (wen1 && (waddr1 != '0))     busy_d[waddr1]   = 1'b0;
    if (iss_en && (iss_addr != '0)) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset explicitly because a clear of every
      // register is part of the block's function; this keeps it out of
      // RAM macros, which is acceptable at this depth.
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= DW'(INITIAL_VAL_32);
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here; port 1 is written last so it
      // wins when both ports target the same address.
      if (wen0 && (waddr0 != '0)) regs_q[waddr0] <= wdata0;
      if (wen1 && (waddr1 != '0)) regs_q[waddr1] <= wdata1;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = raddr[slice_lsb(i, AW) +: AW];

    grp_mp_rdport #(
      .DW(DW),
      .AW(AW)
    ) u_rdport (
      .rst_i     (rst),
      .raddr_i   (addr),
      .arr_data_i(regs_q[addr]),
      .arr_busy_i(busy_q[addr]),
      .wen0_i    (wen0),
      .waddr0_i  (waddr0),
      .wdata0_i  (wdata0),
      .wen1_i    (wen1),
      .waddr1_i  (waddr1),
      .wdata1_i  (wdata1),
      .rdata_o   (rdata[slice_lsb(i, DW) +: DW]),
      .rbusy_o   (rbusy[i])
    );
  end

endmodule

// File: tb/tb_grp_mp.sv
// ---------------------------------------------------------------------------
// tb_grp_mp
//   Directed self-checking bench for grp_mp (DW=32, AW=5, NUM_RD=2).
//   Expected values are hand-computed; bypass-dependent expectations are
//   selected with GRP_MP_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_grp_mp;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int NUM_RD = 2;

`ifdef GRP_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_RD*AW-1:0] raddr;
  logic [NUM_RD*DW-1:0] rdata;
  logic [NUM_RD-1:0]    rbusy;
  logic                 wen0, wen1, iss_en;
  logic [AW-1:0]        waddr0, waddr1, iss_addr;
  logic [DW-1:0]        wdata0, wdata1;
  logic [2**AW-1:0]     busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  grp_mp #(
    .DW(DW),
    .AW(AW),
    .NUM_RD(NUM_RD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .raddr   (raddr),
    .rdata   (rdata),
    .rbusy   (rbusy),
    .wen0    (wen0),
    .waddr0  (waddr0),
    .wdata0  (wdata0),
    .wen1    (wen1),
    .waddr1  (waddr1),
    .wdata1  (wdata1),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after it and
  // outputs are checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
    wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  initial begin
    idle();
    rst = 1'b1;
    set_raddr(5'd5, 5'd31);
    tick();
    tick();
    #2;
    check("rst_rdata", rdata, 64'h0);
    check("rst_rbusy", {62'h0, rbusy}, 64'h0);

    // Reset state over the whole address space.
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      set_raddr(a[AW-1:0], a[AW-1:0]);
      #1;
      check($sformatf("init_rdata_%0d", a), rdata, 64'h0);
      check($sformatf("init_rbusy_%0d", a), {62'h0, rbusy}, 64'h0);
    end
    check("init_busy_vec", {32'h0, busy_vec}, 64'h0);

    // ALU write to r5, read in the write cycle and the next one.
    tick();
    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234_5678;
    set_raddr(5'd5, 5'd0);
    #2;
    check("r5_same_cycle", {32'h0, rdata[31:0]}, BYP ? 64'h1234_5678 : 64'h0);
    tick();
    idle();
    #2;
    check("r5_next_cycle", {32'h0, rdata[31:0]}, 64'h1234_5678);
    check("r0_port1", {32'h0, rdata[63:32]}, 64'h0);

    // Write conflict on r7: load port wins.
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA_AAAA;
    wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555_5555;
    set_raddr(5'd5, 5'd7);
    #1;
    check("r7_conflict_same", {32'h0, rdata[63:32]}, BYP ? 64'h5555_5555 : 64'h0);
    tick();
    idle();
    #2;
    check("r7_conflict", {32'h0, rdata[63:32]}, 64'h5555_5555);
    check("r5_kept", {32'h0, rdata[31:0]}, 64'h1234_5678);

    // Load issue to r9, then its return.
    iss_en = 1'b1; iss_addr = 5'd9;
    set_raddr(5'd9, 5'd5);
    #2;
    check("r9_busy_pre", {63'h0, rbusy[0]}, 64'h0);
    tick();
    idle();
    #2;
    check("busy_vec_r9", {32'h0, busy_vec}, 64'h0000_0200);
    check("rbusy_r9", {62'h0, rbusy}, 64'h1);
    wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hDEAD_BEEF;
    #1;
    check("r9_ret_rdata", {32'h0, rdata[31:0]}, BYP ? 64'hDEAD_BEEF : 64'h0);
    check("r9_ret_rbusy", {63'h0, rbusy[0]}, BYP ? 64'h0 : 64'h1);
    tick();
    idle();
    #2;
    check("busy_vec_clr", {32'h0, busy_vec}, 64'h0);
    check("r9_after_ret", {32'h0, rdata[31:0]}, 64'hDEAD_BEEF);
    check("r9_rbusy_after", {63'h0, rbusy[0]}, 64'h0);

    // Same-cycle issue and return on r9: data lands, busy stays set.
    iss_en = 1'b1; iss_addr = 5'd9;
    wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h0000_9999;
    tick();
    idle();
    #2;
    check("r9_b2b_data", {32'h0, rdata[31:0]}, 64'h0000_9999);
    check("r9_b2b_busy", {32'h0, busy_vec}, 64'h0000_0200);
    check("r9_b2b_rbusy", {63'h0, rbusy[0]}, 64'h1);

    // ALU return (port 0) never clears a busy bit.
    wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h0000_0777;
    tick();
    idle();
    #2;
    check("wen0_no_clr", {32'h0, busy_vec}, 64'h0000_0200);

    // Register 0: writes and issues are discarded.
    wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
    wen1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    set_raddr(5'd0, 5'd0);
    #1;
    check("r0_same_cycle", rdata, 64'h0);
    tick();
    idle();
    #2;
    check("r0_rdata", rdata, 64'h0);
    check("r0_busy", {32'h0, busy_vec}, 64'h0000_0200);

    // Set busy[3] with a write to r3, then reset mid-operation.
    iss_en = 1'b1; iss_addr = 5'd3;
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h0000_3333;
    set_raddr(5'd5, 5'd3);
    tick();
    idle();
    #2;
    check("r3_written", {32'h0, rdata[63:32]}, 64'h0000_3333);
    check("busy_3_9", {32'h0, busy_vec}, 64'h0000_0208);
    check("rbusy_r3", {62'h0, rbusy}, 64'h2);
    rst = 1'b1;
    #1;
    check("rst_mid_rdata", rdata, 64'h0);
    check("rst_mid_rbusy", {62'h0, rbusy}, 64'h0);
    tick();
    rst = 1'b0;
    #2;
    check("post_rst_busy", {32'h0, busy_vec}, 64'h0);
    check("post_rst_r3_r5", rdata, 64'h0);

    // Late load return after reset writes normally.
    wen1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h0000_4444;
    tick();
    idle();
    #2;
    check("late_ret_data", {32'h0, rdata[63:32]}, 64'h0000_4444);
    check("late_ret_busy", {32'h0, busy_vec}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/grp_mp.md
Name: grp_mp

Overview:
- Parametrised multi-port general register file; next generation of the single-write, two-read GPR block for the pipelined core.
- Sits between decode (read ports) and writeback (two write ports: ALU result port 0, load-return port 1).
- Adds synchronous clearing of all registers, N read ports, and a per-register pending-load scoreboard that drives decode stalls.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers; register 0 hardwired to zero.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- raddr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NUM_RD*DW  combinational read data, packed the same way as raddr.
- rbusy  out  NUM_RD  port i's register has a pending load.
- wen0  in  1  ALU writeback enable.
- waddr0  in  AW  ALU writeback address.
- wdata0  in  DW  ALU writeback data.
- wen1  in  1  load-return write enable.
- waddr1  in  AW  load-return address.
- wdata1  in  DW  load-return data.
- iss_en  in  1  a load is issued this cycle.
- iss_addr  in  AW  destination register of the issued load.
- busy_vec  out  2**AW  raw scoreboard state, for debug and the hazard unit.

Behaviour:
- Reset (rst=1 at posedge):
  - All registers and all busy bits cleared to 0.
  - While rst=1, rdata=0 and rbusy=0 on every port, regardless of the addresses presented.
- Writes:
  - On posedge with rst=0, wenX=1 and waddrX!=0: reg[waddrX] <= wdataX.
  - Writes to address 0 are discarded.
- Write conflict: wen0 and wen1 to the same nonzero address in one cycle -> port 1 (load) wins; port 0 data is dropped.
- Reads:
  - Combinational, 0-cycle latency.
  - raddr=0 -> rdata=0, rbusy=0.
  - Otherwise rdata = reg[raddr], subject to bypass (Optional Feature).
- Scoreboard, per register r != 0, evaluated on posedge with rst=0:
  - Set when iss_en=1 and iss_addr=r.
  - Cleared when wen1=1 and waddr1=r.
  - Set and clear in the same cycle on the same r -> set wins (back-to-back loads to one destination).
  - iss_en with iss_addr=0 is ignored.
  - busy[0] is always 0.
  - wen0 never affects busy bits.
- rbusy[i]:
  - Equals busy[raddr_i] when bypass is compiled out.
  - With bypass compiled in, rbusy[i]=0 if wen1=1 and waddr1=raddr_i in the same cycle (the load data is forwarded).
- A reset mid-operation discards all pending loads; a load return arriving after reset writes data normally and clears a busy bit that is already 0 (no error).
- No internal pipeline; the only state is the register array and the busy vector.

Optional Feature:
- Macro: GRP_MP_BYPASS_EN.
- Defined:
  - A read whose address matches a same-cycle nonzero write returns the write data, with the same port-1-wins priority.
  - The rbusy suppression described under Behaviour applies.
- Undefined:
  - Reads return the pre-edge register contents.
  - rbusy reflects the raw busy bit.
  - Writeback and decode must then be split by one cycle outside the block.

Decomposition:
- Shared header (alongside the existing head.v): zero constant INITIAL_VAL_32, default DW/AW, and the port-slice helper macro for packed buses.
- One natural sub-module, grp_mp_rdport: a single read port containing the zero check, the bypass mux and the rbusy logic, instantiated NUM_RD times in a generate loop.
- The scoreboard stays inline; it is too small to split out.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rdata=0, rbusy=0, busy_vec=0.
- wen0=1, waddr0=5, wdata0=0x1234_5678, and the next cycle raddr0=5 -> rdata=0x12345678. With bypass: raddr0=5 in the write cycle itself -> 0x12345678. Without bypass: that same read -> 0.
- wen0 and wen1 both to address 7, with data 0xAAAA_AAAA and 0x5555_5555 -> reg7 reads 0x55555555.
- iss_en to address 9 -> busy_vec[9]=1 and rbusy=1 when reading r9. Then wen1 to r9 with 0xDEAD_BEEF -> busy cleared; bypass build returns rdata=0xDEADBEEF with rbusy=0 in that same cycle.
- Same-cycle iss_en to r9 and wen1 to r9 -> r9 receives the data and busy[9] stays 1.
- Write 0xFFFF_FFFF to r0 and iss_en to r0 -> r0 reads 0 and busy_vec[0]=0. Then set busy[3] and assert rst for one cycle -> busy_vec=0 and r3 reads 0.
